// File: rtl/audio_pwm_out.sv
// Mono audio back end: ramped volume gain on the 8-bit PCM stream, then a
// period-synchronous PWM with an enable/fade FSM that keeps the amp pop-free.
module audio_pwm_out #(
  parameter int PWM_BITS        = 8,   // must be >= 8; samples are left-aligned
  parameter int FADE_STEP_TICKS = 64,
  parameter int MAX_GAIN        = 16
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] sample_in,
  input  logic       sample_tick,
  input  logic       enable,
  input  logic [4:0] volume,
  output logic       pwm_out,
  output logic       amp_en,
  output logic [4:0] gain_level,
  output logic       fade_busy
);

  typedef enum logic [1:0] {S_OFF, S_FADE_IN, S_PLAY, S_FADE_OUT} state_t;

  localparam int         FW   = (FADE_STEP_TICKS > 1) ? $clog2(FADE_STEP_TICKS) : 1;
  localparam logic [4:0] GMAX = 5'(MAX_GAIN);

  state_t                state, state_nxt;
  logic [4:0]            gain, gain_nxt, tgt;
  logic [FW-1:0]         fade_cnt;
  logic                  step;

  logic [7:0]            smp;
  logic                  smp_vld;
  logic signed [8:0]     ctr;
  logic signed [14:0]    prod, lvl;
  logic [7:0]            scaled, scaled_nxt;

  logic [PWM_BITS-1:0]   pwm_cnt, duty;
  logic                  wrap;

  assign tgt  = (volume > GMAX) ? GMAX : volume;
  assign step = sample_tick && (fade_cnt == FW'(FADE_STEP_TICKS - 1));
  assign wrap = &pwm_cnt;

  assign amp_en     = (state != S_OFF);
  assign fade_busy  = (state == S_FADE_IN) || (state == S_FADE_OUT);
  assign gain_level = gain;

  // A state change always takes priority over a gain step in the same cycle.
  always_comb begin
    state_nxt = state;
    gain_nxt  = gain;
    unique case (state)
      S_OFF: begin
        gain_nxt = '0;
        if (enable) state_nxt = S_FADE_IN;
      end
      S_FADE_IN: begin
        if (!enable)          state_nxt = S_FADE_OUT;
        else if (gain >= tgt) state_nxt = S_PLAY;
        else if (step)        gain_nxt  = gain + 5'd1;
      end
      S_PLAY: begin
        if (!enable) state_nxt = S_FADE_OUT;
        else if (step) begin
          if (gain < tgt)      gain_nxt = gain + 5'd1;
          else if (gain > tgt) gain_nxt = gain - 5'd1;
        end
      end
      S_FADE_OUT: begin
        if (enable)            state_nxt = S_FADE_IN;
        else if (gain == '0)   state_nxt = S_OFF;
        else if (step)         gain_nxt  = gain - 5'd1;
      end
      default: begin
        state_nxt = S_OFF;
        gain_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= S_OFF;
      gain     <= '0;
      fade_cnt <= '0;
    end else begin
      state <= state_nxt;
      gain  <= gain_nxt;
      if (state_nxt != state)  fade_cnt <= '0;
      else if (sample_tick)    fade_cnt <= step ? '0 : fade_cnt + FW'(1);
    end
  end

  // Signed scale around the 128 midpoint; >>> floors toward -inf.
  always_comb begin
    ctr  = $signed({1'b0, smp}) - 9'sd128;
    prod = ctr * $signed({1'b0, gain});
    lvl  = (prod >>> 4) + 15'sd128;
    if (lvl < 15'sd0)        scaled_nxt = 8'd0;
    else if (lvl > 15'sd255) scaled_nxt = 8'd255;
    else                     scaled_nxt = lvl[7:0];
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      smp     <= 8'd128;
      smp_vld <= 1'b0;
      scaled  <= 8'd128;
    end else begin
      smp_vld <= sample_tick;
      if (sample_tick) smp    <= sample_in;
      if (smp_vld)     scaled <= scaled_nxt;
    end
  end

  // Duty only moves at the period boundary so each PWM period is whole.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pwm_cnt <= '0;
      duty    <= '0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (state == S_OFF) duty <= '0;
      else if (wrap)      duty <= PWM_BITS'(scaled) << (PWM_BITS - 8);
      pwm_out <= (state != S_OFF) && (pwm_cnt < duty);
    end
  end

endmodule

// File: tb/tb_audio_pwm_out.sv
// Directed bench for audio_pwm_out: fade/slew sequencing plus duty checks
// measured as high-clock counts over one PWM period against a queued model.
module tb_audio_pwm_out;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [7:0] sample_in;
  logic       sample_tick;
  logic       enable;
  logic [4:0] volume;
  logic       pwm_out, amp_en, fade_busy;
  logic [4:0] gain_level;

  int n_pass = 0;
  int n_tot  = 0;
  int n_fail = 0;
  int ph     = 0;     // sample ticks since the fade counter last cleared, mod 64
  int exp_q[$];

  audio_pwm_out dut (
    .CLK(CLK), .RESET_N(RESET_N), .sample_in(sample_in), .sample_tick(sample_tick),
    .enable(enable), .volume(volume), .pwm_out(pwm_out), .amp_en(amp_en),
    .gain_level(gain_level), .fade_busy(fade_busy)
  );

  always #5 CLK = ~CLK;

  function automatic int exp_duty(int s, int g);
    int p, q;
    p = (s - 128) * g;
    if (p >= 0) q = p / 16;
    else        q = -((-p + 15) / 16);
    q = q + 128;
    if (q < 0)   q = 0;
    if (q > 255) q = 255;
    return q;
  endfunction

  function automatic int n_for(int k);
    return (64 - ph) + 64 * (k - 1);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_tot++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic pop_chk(string tag, int obs);
    if (exp_q.size() == 0) begin
      n_tot++;
      n_fail++;
      $error("FAIL %s: observed %0d expected <scoreboard empty>", tag, obs);
    end else begin
      chk(tag, obs, exp_q.pop_front());
    end
  endtask

  task automatic clk1;
    @(posedge CLK);
    #1;
  endtask

  task automatic tick_nogap(logic [7:0] s);
    sample_in   = s;
    sample_tick = 1'b1;
    clk1();
    sample_tick = 1'b0;
    ph = (ph + 1) % 64;
  endtask

  task automatic ticks(int n, logic [7:0] s);
    repeat (n) begin
      tick_nogap(s);
      clk1();
    end
  endtask

  task automatic push_tick(logic [7:0] s, int g);
    exp_q.push_back(exp_duty(s, g));
    ticks(1, s);
  endtask

  task automatic measure(string tag);
    int hi;
    repeat (300) clk1();
    hi = 0;
    repeat (256) begin
      hi += int'(pwm_out);
      clk1();
    end
    pop_chk(tag, hi);
  endtask

  initial begin
    int hi, prev;
    bit found;

    RESET_N = 1'b0; enable = 1'b0; volume = 5'd0; sample_in = 8'h80; sample_tick = 1'b0;
    repeat (3) clk1();
    chk("rst_pwm", pwm_out, 0);
    chk("rst_amp", amp_en, 0);
    chk("rst_gain", gain_level, 0);
    chk("rst_busy", fade_busy, 0);
    RESET_N = 1'b1;
    clk1();

    // Full fade-in at volume 16 with full-scale samples
    volume = 5'd16; enable = 1'b1;
    clk1(); ph = 0;
    chk("fin_amp", amp_en, 1);
    chk("fin_busy", fade_busy, 1);
    ticks(63, 8'hFF);
    chk("fin_no_step_63", gain_level, 0);
    ticks(1, 8'hFF);
    chk("fin_step_64", gain_level, 1);
    ticks(959, 8'hFF);
    chk("fin_gain15", gain_level, 15);
    chk("fin_busy15", fade_busy, 1);
    exp_q.push_back(exp_duty(8'hFF, 16));
    ticks(1, 8'hFF);
    chk("fin_gain16", gain_level, 16);
    chk("fin_done", fade_busy, 0);
    measure("duty_ff_g16");

    // Volume slew 16 -> 4 stays in PLAY, then up to 8
    volume = 5'd4;
    ticks(n_for(12) - 1, 8'h80);
    chk("slew_gain5", gain_level, 5);
    chk("slew_busy", fade_busy, 0);
    ticks(1, 8'h80);
    chk("slew_gain4", gain_level, 4);
    chk("slew_amp", amp_en, 1);
    volume = 5'd8;
    ticks(n_for(4), 8'h80);
    chk("slew_gain8", gain_level, 8);
    push_tick(8'hC0, 8); measure("duty_c0_g8");
    push_tick(8'h40, 8); measure("duty_40_g8");
    push_tick(8'h80, 8); measure("duty_80_g8");

    // Floor rounding at gain 1, bottom rail at gain 16
    volume = 5'd1;
    ticks(n_for(7), 8'h80);
    chk("gain1", gain_level, 1);
    push_tick(8'h7F, 1); measure("duty_7f_g1");
    volume = 5'd16;
    ticks(n_for(15), 8'h80);
    chk("gain16b", gain_level, 16);
    push_tick(8'h00, 16); measure("duty_00_g16");

    // Mid-period scaled change must wait for the wrap
    push_tick(8'h80, 16);
    repeat (300) clk1();
    found = 0;
    prev  = int'(pwm_out);
    for (int i = 0; i < 600 && !found; i++) begin
      clk1();
      if (prev == 0 && pwm_out == 1'b1) found = 1;
      prev = int'(pwm_out);
    end
    if (!found) begin
      n_tot++;
      n_fail++;
      $error("FAIL period_start: observed no pwm rise expected rise within 600 clocks");
    end
    hi = 1;
    for (int i = 1; i < 256; i++) begin
      if (i == 50) begin
        exp_q.push_back(exp_duty(8'hFF, 16));
        sample_in   = 8'hFF;
        sample_tick = 1'b1;
      end
      clk1();
      if (i == 50) ph = (ph + 1) % 64;
      sample_tick = 1'b0;
      hi += int'(pwm_out);
    end
    pop_chk("old_duty_period", hi);
    hi = 0;
    repeat (256) begin
      clk1();
      hi += int'(pwm_out);
    end
    pop_chk("new_duty_period", hi);

    // Fade reversal: drop at 10, re-raise at 6 with clamped volume
    volume = 5'd10;
    ticks(n_for(6), 8'h80);
    chk("rev_gain10", gain_level, 10);
    enable = 1'b0;
    clk1(); ph = 0;
    chk("fout_busy", fade_busy, 1);
    ticks(63, 8'h80);
    chk("fout_hold", gain_level, 10);
    ticks(1, 8'h80);
    chk("fout_gain9", gain_level, 9);
    ticks(192, 8'h80);
    chk("fout_gain6", gain_level, 6);
    volume = 5'd31; enable = 1'b1;
    clk1(); ph = 0;
    chk("refin_busy", fade_busy, 1);
    chk("refin_gain6", gain_level, 6);
    ticks(64, 8'h80);
    chk("refin_gain7", gain_level, 7);
    ticks(575, 8'h80);
    chk("refin_gain15", gain_level, 15);
    ticks(1, 8'h80);
    chk("clamp_gain16", gain_level, 16);
    chk("clamp_play", fade_busy, 0);

    // Complete fade-out into OFF
    enable = 1'b0;
    clk1(); ph = 0;
    ticks(1023, 8'h80);
    chk("fout_gain1", gain_level, 1);
    tick_nogap(8'h80);
    chk("fout_gain0", gain_level, 0);
    chk("fout_amp_hold", amp_en, 1);
    clk1();
    chk("off_amp", amp_en, 0);
    chk("off_busy", fade_busy, 0);
    exp_q.push_back(0);
    measure("off_pwm_low");

    // Reset mid-PLAY at gain 16
    volume = 5'd16; enable = 1'b1;
    clk1(); ph = 0;
    ticks(1024, 8'hFF);
    chk("pre_rst_gain", gain_level, 16);
    repeat (20) clk1();
    #2 RESET_N = 1'b0;
    #1;
    chk("mid_rst_pwm", pwm_out, 0);
    chk("mid_rst_amp", amp_en, 0);
    chk("mid_rst_gain", gain_level, 0);
    chk("mid_rst_busy", fade_busy, 0);
    enable = 1'b0; volume = 5'd0;
    clk1();
    RESET_N = 1'b1;
    clk1();

    // Zero target: FADE_IN lasts one cycle
    enable = 1'b1;
    clk1();
    chk("t0_fadein", fade_busy, 1);
    clk1();
    chk("t0_play", fade_busy, 0);
    chk("t0_amp", amp_en, 1);
    chk("t0_gain", gain_level, 0);

    if (n_fail != 0) $display("%0d comparisons disagreed", n_fail);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/audio_pwm_out.md
Name: audio_pwm_out

Overview:
- Consumes the 8-bit unsigned 16 kHz sample stream and its sample tick from the BRAM audio player.
- Applies a ramped volume gain, then converts each sample to a PWM waveform for the board's mono audio amplifier.
- Includes an enable/fade state machine so the amplifier turns on and off without pops.
- Sits directly downstream of the BRAM player and drives the top-level audio pins.

Parameters:
- PWM_BITS, 8, PWM counter width; period is 2^PWM_BITS clocks (256 clocks, about 390.6 kHz at 100 MHz).
- FADE_STEP_TICKS, 64, sample ticks per one-step gain change during fades and volume slews.
- MAX_GAIN, 16, unity gain code; gain/volume range is 0..MAX_GAIN.

Ports:
- CLK  input  1  system clock, 100 MHz.
- RESET_N  input  1  asynchronous active-low reset.
- sample_in  input  8  unsigned PCM sample, midpoint 128.
- sample_tick  input  1  one-cycle strobe; sample_in is valid in the same cycle.
- enable  input  1  level; 1 = play, 0 = fade out and shut down.
- volume  input  5  target gain 0..16; values above 16 clamp to 16.
- pwm_out  output  1  PWM audio output.
- amp_en  output  1  amplifier shutdown-bar.
- gain_level  output  5  current applied gain.
- fade_busy  output  1  high in FADE_IN and FADE_OUT.

Behaviour:
- Reset (async, RESET_N low): state OFF; pwm_out, amp_en, gain_level, fade_busy = 0; sample register = 128; duty = 0; PWM counter and fade counter = 0.
- Sample path:
  - Sample register loads sample_in on the clock edge where sample_tick = 1.
  - Next cycle, the scale register computes c = sample - 128 as a 9-bit signed value, then p = c * gain_level as signed.
  - p is arithmetically shifted right by 4 (floor toward -inf), and 128 is added.
  - The result saturates to 0..255 (cannot exceed the range when gain ≤ 16; clamp anyway).
  - sample_tick to scaled-result latency is 2 cycles.
- PWM:
  - Free-running PWM_BITS counter, 0..255 then wraps.
  - duty loads the scaled result only in the cycle the counter wraps 255→0. It is glitch-free: at most one update per period, and the latest scaled value wins.
  - pwm_out is registered and equals (counter < duty). Duty 0 means always low; duty 255 means high 255 of 256 clocks.
  - In OFF, duty is forced to 0 and pwm_out = 0.
- Fade counter:
  - Counts sample_ticks only; it resets to 0 on every state change.
  - A "step" fires on the tick where the count reaches FADE_STEP_TICKS-1, and the counter then returns to 0.
- Effective target: T = min(volume, 16).
- FSM:
  - OFF: amp_en = 0, gain = 0. When enable = 1, go to FADE_IN.
  - FADE_IN: amp_en = 1, fade_busy = 1. On each step, gain increments by 1.
    - When gain == T, go to PLAY. If T == 0 on entry, go to PLAY on the next cycle.
    - When enable = 0, go to FADE_OUT, keeping the current gain.
  - PLAY: amp_en = 1. On each step, gain moves 1 toward T; it holds when equal.
    - When enable = 0, go to FADE_OUT.
    - Volume changes never cause gain jumps.
  - FADE_OUT: amp_en = 1, fade_busy = 1. On each step, gain decrements by 1.
    - When gain reaches 0, go to OFF. amp_en drops the cycle OFF is entered.
    - If gain is already 0 on entry, go to OFF next cycle.
    - When enable = 1, go to FADE_IN from the current gain.
- Simultaneous events:
  - A step and a state change in the same cycle: the state change wins and no gain update occurs.
  - sample_tick absent: gain and FSM steps freeze, and PWM keeps the last duty.
- Reset mid-fade: immediate return to OFF values; no residual gain.

Test Plan:
- Reset mid-PLAY with gain 16 → next cycle pwm_out = 0, amp_en = 0, gain_level = 0, state OFF.
- enable=1, volume=16, constant sample 0xFF with tick every 6250 clocks:
  - gain rises 0→16 in 16×64 ticks, then fade_busy drops.
  - Final duty 255; pwm_out high 255 of every 256 clocks.
- In PLAY with gain=8: sample 0xC0 → duty 160; sample 0x40 → duty 96; sample 0x80 → duty 128.
- Floor rounding, gain=1, sample 0x7F → duty 127; gain=16, sample 0x00 → duty 0, pwm_out never high.
- Duty update timing:
  - Scaled result changes mid-period → pwm_out for the current period still uses the old duty.
  - The new duty applies from the counter wrap.
- Fade reversal and volume slews:
  - enable dropped at gain 10 → gain falls by 1 per 64 ticks.
  - enable re-raised at gain 6 → FADE_IN resumes from 6 up to T.
  - Volume 31 clamps to T = 16.
  - volume 16→4 in PLAY slews down over 12×64 ticks while the FSM stays in PLAY.
